// File: rtl/sprite_compositor_pkg.sv
// Shared constants and helpers for the sprite compositor.
// Latency: n/a (package only).
// Backpressure: n/a.
package sprite_compositor_pkg;

    localparam int RGB_W           = 12;
    localparam int TRANSPARENT_IDX = 0;
    localparam logic [RGB_W-1:0] BLACK      = 12'h000;
    localparam logic [RGB_W-1:0] DEFAULT_BG = 12'h237;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_compositor_window.sv
// Per-layer hit test and sprite ROM address generation for one scan position.
// Latency: combinational; the compositor registers the results.
// Backpressure: none, evaluated every pixel clock.
module sprite_window
    import sprite_compositor_pkg::*;
#(
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int SPR_W = 32,
    parameter int SPR_H = 32,
    parameter int AW    = clog2(SPR_W * SPR_H)
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [X_W-1:0] lx,
    input  logic [Y_W-1:0] ly,
    output logic           hit,
    output logic [AW-1:0]  addr
);

    localparam int XB = clog2(SPR_W);
    localparam int YB = AW - XB;
    localparam logic [X_W:0] SPR_W_EXT = (X_W+1)'(SPR_W);
    localparam logic [Y_W:0] SPR_H_EXT = (Y_W+1)'(SPR_H);

    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;

    // Ends are one bit wider so a sprite near the edge clips instead of wrapping to 0.
    // SPR_W is a power of two, so row*SPR_W+col is a plain concatenation.
    always_comb begin
        x_end = {1'b0, lx} + SPR_W_EXT;
        y_end = {1'b0, ly} + SPR_H_EXT;
        hit   = (x >= lx) && ({1'b0, x} < x_end) && (y >= ly) && ({1'b0, y} < y_end);
        addr  = hit ? {YB'(y - ly), XB'(x - lx)} : '0;
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: window hit, sprite ROM fetch, palette lookup, priority blend.
// Latency: 3 cycles from (x,y,active) to VGA_*; config commits at frame_start.
// Backpressure: cfg_ready drops during reset and the frame_start cycle only.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int NUM_LAYERS   = 8,
    parameter int SPR_W        = 32,
    parameter int SPR_H        = 32,
    parameter int IDX_W        = 6,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter logic [RGB_W-1:0] BG_COLOR = DEFAULT_BG,
    parameter int BLINK_FRAMES = 30,
    localparam int LW = (clog2(NUM_LAYERS) < 1) ? 1 : clog2(NUM_LAYERS),
    localparam int AW = clog2(SPR_W * SPR_H)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        active,
    input  logic                        frame_start,
    input  logic [X_W-1:0]              x,
    input  logic [Y_W-1:0]              y,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [LW-1:0]               cfg_layer,
    input  logic [X_W-1:0]              cfg_x,
    input  logic [Y_W-1:0]              cfg_y,
    input  logic                        cfg_show,
    input  logic                        cfg_blink,
    input  logic                        pal_we,
    input  logic [LW-1:0]               pal_layer,
    input  logic [IDX_W-1:0]            pal_addr,
    input  logic [RGB_W-1:0]            pal_data,
    output logic [NUM_LAYERS*AW-1:0]    spr_addr,
    input  logic [NUM_LAYERS*IDX_W-1:0] spr_data,
    output logic [3:0]                  VGA_R,
    output logic [3:0]                  VGA_G,
    output logic [3:0]                  VGA_B
);

    localparam int CNT_W = (clog2(BLINK_FRAMES + 1) < 1) ? 1 : clog2(BLINK_FRAMES + 1);

    logic [X_W-1:0]        sh_x [NUM_LAYERS];
    logic [Y_W-1:0]        sh_y [NUM_LAYERS];
    logic [X_W-1:0]        lv_x [NUM_LAYERS];
    logic [Y_W-1:0]        lv_y [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] sh_show, sh_blink, lv_show, lv_blink;
    logic [CNT_W-1:0]      frame_cnt;
    logic                  blink_phase;
    logic [RGB_W-1:0]      pal [NUM_LAYERS][2**IDX_W];

    logic [NUM_LAYERS-1:0] vis, win_hit, s1_hit, s2_hit;
    logic [AW-1:0]         win_addr [NUM_LAYERS];
    logic                  s1_vld, s1_active, s2_vld, s2_active;
    logic [IDX_W-1:0]      idx;
    logic [RGB_W-1:0]      pix, rgb_q;
    logic                  cfg_fire;

    // The frame_start cycle is reserved for the shadow->live copy, so no write can race it.
    assign cfg_ready = !reset && !frame_start;
    assign cfg_fire  = cfg_valid && cfg_ready;

    // Shadow regs take CPU writes anytime; live regs only change at frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                sh_x[i] <= '0;
                sh_y[i] <= '0;
                lv_x[i] <= '0;
                lv_y[i] <= '0;
            end
            sh_show  <= '0;
            sh_blink <= '0;
            lv_show  <= '0;
            lv_blink <= '0;
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (cfg_fire && cfg_layer == LW'(i)) begin
                    sh_x[i]     <= cfg_x;
                    sh_y[i]     <= cfg_y;
                    sh_show[i]  <= cfg_show;
                    sh_blink[i] <= cfg_blink;
                end
            end
            if (frame_start) begin
                lv_x     <= sh_x;
                lv_y     <= sh_y;
                lv_show  <= sh_show;
                lv_blink <= sh_blink;
            end
        end
    end

    // Frame counter: blink_phase toggles every BLINK_FRAMES frame_start pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Palette RAM: synchronous write, asynchronous read; the S3 register sees pre-write data.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (pal_we && pal_layer == LW'(i)) begin
                pal[i][pal_addr] <= pal_data;
            end
        end
    end

    // A blinking layer is hidden during the odd blink phase.
    always_comb begin
        vis = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            vis[i] = lv_show[i] && !(lv_blink[i] && blink_phase);
        end
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_win
        sprite_window #(
            .X_W   (X_W),
            .Y_W   (Y_W),
            .SPR_W (SPR_W),
            .SPR_H (SPR_H),
            .AW    (AW)
        ) u_win (
            .x    (x),
            .y    (y),
            .lx   (lv_x[g]),
            .ly   (lv_y[g]),
            .hit  (win_hit[g]),
            .addr (win_addr[g])
        );
    end

    // S1/S2: register ROM addresses and qualifiers, then align them with the ROM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld    <= 1'b0;
            s1_active <= 1'b0;
            s1_hit    <= '0;
            s2_vld    <= 1'b0;
            s2_active <= 1'b0;
            s2_hit    <= '0;
            spr_addr  <= '0;
        end else begin
            s1_vld    <= 1'b1;
            s1_active <= active;
            s1_hit    <= win_hit & vis;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                spr_addr[i*AW +: AW] <= win_addr[i];
            end
            s2_vld    <= s1_vld;
            s2_active <= s1_active;
            s2_hit    <= s1_hit;
        end
    end

    // Priority pick: scan from the lowest priority up so layer 0 overwrites last.
    always_comb begin
        pix = BG_COLOR;
        idx = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            idx = spr_data[i*IDX_W +: IDX_W];
            if (s2_hit[i] && idx != IDX_W'(TRANSPARENT_IDX)) begin
                pix = pal[i][idx];
            end
        end
    end

    // S3: output register; blanking and pipeline refill force black.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= BLACK;
        end else if (!s2_vld || !s2_active) begin
            rgb_q <= BLACK;
        end else begin
            rgb_q <= pix;
        end
    end

    assign VGA_R = rgb_q[11:8];
    assign VGA_G = rgb_q[7:4];
    assign VGA_B = rgb_q[3:0];

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a frame-level reference model.
// Latency: checks every cycle against the model, plus literal pins.
// Backpressure: cfg_ready checked every cycle.
module tb_sprite_compositor;

    localparam int NL = 8;
    localparam int BF = 2;
    localparam int AW = 10;
    localparam int IW = 6;

    logic             clk = 1'b0;
    logic             reset, active, frame_start;
    logic [9:0]       x;
    logic [8:0]       y;
    logic             cfg_valid, cfg_ready;
    logic [2:0]       cfg_layer;
    logic [9:0]       cfg_x;
    logic [8:0]       cfg_y;
    logic             cfg_show, cfg_blink;
    logic             pal_we;
    logic [2:0]       pal_layer;
    logic [5:0]       pal_addr;
    logic [11:0]      pal_data;
    logic [NL*AW-1:0] spr_addr;
    logic [NL*IW-1:0] spr_data;
    logic [3:0]       VGA_R, VGA_G, VGA_B;

    sprite_compositor #(.BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .active(active), .frame_start(frame_start),
        .x(x), .y(y), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_layer(cfg_layer), .cfg_x(cfg_x), .cfg_y(cfg_y),
        .cfg_show(cfg_show), .cfg_blink(cfg_blink),
        .pal_we(pal_we), .pal_layer(pal_layer), .pal_addr(pal_addr), .pal_data(pal_data),
        .spr_addr(spr_addr), .spr_data(spr_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    always #5 clk = ~clk;

    // External sprite ROMs, one-cycle read latency.
    logic [5:0] rom [NL][1024];
    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) begin
            spr_data[l*IW +: IW] <= rom[l][spr_addr[l*AW +: AW]];
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level state observed from the bench's own stimulus.
    int          m_sh_x [NL], m_sh_y [NL], m_lv_x [NL], m_lv_y [NL];
    bit          m_sh_show [NL], m_sh_blink [NL], m_lv_show [NL], m_lv_blink [NL];
    logic [11:0] m_pal [NL][64];
    int          m_nfs = 0;
    bit          armed = 0;
    bit          rst_d1 = 1, rst_d2 = 1;
    logic [11:0] f_now, f_d1 = 0, f_d2 = 0, exp_vga = 0;

    function automatic logic [11:0] model_pix(input int px, input int py, input logic act);
        int ph;
        if (!act) return 12'h000;
        ph = (m_nfs / BF) % 2;
        for (int l = 0; l < NL; l++) begin
            if (m_lv_show[l] && !(m_lv_blink[l] && ph == 1) &&
                px >= m_lv_x[l] && px < m_lv_x[l] + 32 &&
                py >= m_lv_y[l] && py < m_lv_y[l] + 32) begin
                int a;
                a = (py - m_lv_y[l]) * 32 + (px - m_lv_x[l]);
                if (rom[l][a] != 6'd0) return m_pal[l][rom[l][a]];
            end
        end
        return 12'h237;
    endfunction

    always @(posedge clk) begin
        f_now   = model_pix(int'(x), int'(y), active);
        exp_vga = reset ? 12'h000 : ((rst_d1 || rst_d2) ? 12'h000 : f_d2);
        f_d2 = f_d1; f_d1 = f_now; rst_d2 = rst_d1; rst_d1 = reset;
        if (reset) begin
            armed = 1;
            m_nfs = 0;
            for (int l = 0; l < NL; l++) begin
                m_sh_x[l] = 0; m_sh_y[l] = 0; m_sh_show[l] = 0; m_sh_blink[l] = 0;
                m_lv_x[l] = 0; m_lv_y[l] = 0; m_lv_show[l] = 0; m_lv_blink[l] = 0;
            end
        end else begin
            if (cfg_valid && !frame_start) begin
                m_sh_x[cfg_layer] = int'(cfg_x);
                m_sh_y[cfg_layer] = int'(cfg_y);
                m_sh_show[cfg_layer] = cfg_show;
                m_sh_blink[cfg_layer] = cfg_blink;
            end
            if (frame_start) begin
                m_lv_x = m_sh_x; m_lv_y = m_sh_y;
                m_lv_show = m_sh_show; m_lv_blink = m_sh_blink;
                m_nfs++;
            end
        end
        if (pal_we) m_pal[pal_layer][pal_addr] = pal_data;
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        #2;
        if (armed) begin
            check("model_vga", {20'h0, VGA_R, VGA_G, VGA_B}, {20'h0, exp_vga});
            check("model_ready", {31'h0, cfg_ready}, {31'h0, !reset && !frame_start});
        end
    end

    task automatic cfg_write(input int l, input int cx, input int cy, input bit sh, input bit bl);
        @(negedge clk);
        cfg_valid = 1; cfg_layer = 3'(l); cfg_x = 10'(cx); cfg_y = 9'(cy);
        cfg_show = sh; cfg_blink = bl;
        @(negedge clk);
        cfg_valid = 0;
    endtask

    task automatic pal_write(input int l, input int a, input logic [11:0] d);
        @(negedge clk);
        pal_we = 1; pal_layer = 3'(l); pal_addr = 6'(a); pal_data = d;
        @(negedge clk);
        pal_we = 0;
    endtask

    task automatic commit();
        @(negedge clk);
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
    endtask

    task automatic probe(input int px, input int py, input logic act, input logic [11:0] e, input string name);
        @(negedge clk);
        x = 10'(px); y = 9'(py); active = act;
        repeat (3) @(negedge clk);
        #1 check(name, {20'h0, VGA_R, VGA_G, VGA_B}, {20'h0, e});
    endtask

    logic [7:0] blink_vis = 8'b1001_1001;  // bit k-1: visible after k-th frame_start

    initial begin
        reset = 1; active = 1; x = 100; y = 100; frame_start = 0;
        cfg_valid = 0; cfg_layer = 0; cfg_x = 0; cfg_y = 0; cfg_show = 0; cfg_blink = 0;
        pal_we = 0; pal_layer = 0; pal_addr = 0; pal_data = 0;
        for (int l = 0; l < NL; l++)
            for (int a = 0; a < 1024; a++)
                rom[l][a] = 6'((a * 7 + l * 13) % 64);
        rom[0][69] = 5;
        rom[0][394] = 0; rom[1][394] = 3;
        rom[0][395] = 2; rom[1][395] = 3;
        rom[2][165] = 9; rom[3][165] = 4; rom[4][165] = 1; rom[5][165] = 6;

        // 1: reset behaviour and pipeline refill
        repeat (4) begin
            @(negedge clk);
            #1 check("rst_vga", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
            check("rst_ready", {31'h0, cfg_ready}, 32'h0);
        end
        reset = 0;
        @(negedge clk); #1 check("refill_1", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        check("ready_after_rst", {31'h0, cfg_ready}, 32'h1);
        @(negedge clk); #1 check("refill_2", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        @(negedge clk); #1 check("refill_bg", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h237);

        // Fill every palette with known colours while blanked
        @(negedge clk); active = 0;
        for (int l = 0; l < NL; l++)
            for (int a = 0; a < 64; a++) begin
                @(negedge clk);
                pal_we = 1; pal_layer = 3'(l); pal_addr = 6'(a); pal_data = 12'(l * 300 + a * 37);
            end
        @(negedge clk); pal_we = 0;
        pal_write(0, 5, 12'hF00); pal_write(1, 3, 12'h00F); pal_write(0, 2, 12'h0F0);
        pal_write(2, 9, 12'hABC); pal_write(3, 4, 12'h456); pal_write(4, 1, 12'h777);
        pal_write(5, 6, 12'hC0C);

        // 2: single layer, exact address and latency
        cfg_write(0, 290, 398, 1, 0);
        commit();
        @(negedge clk); x = 295; y = 400; active = 1;
        @(negedge clk); #1 check("t2_addr", {22'h0, spr_addr[9:0]}, 32'd69);
        x = 0; y = 0; active = 1;
        @(negedge clk); #1 check("t2_pre", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        @(negedge clk); #1 check("t2_red", {20'h0, VGA_R, VGA_G, VGA_B}, 32'hF00);
        @(negedge clk); #1 check("t2_post", {20'h0, VGA_R, VGA_G, VGA_B}, 32'h237);

        // 3: overlapping layers, transparency and priority
        cfg_write(1, 290, 398, 1, 0);
        commit();
        for (int px = 280; px <= 340; px++) begin
            @(negedge clk); x = 10'(px); y = 410; active = 1;
        end
        probe(300, 410, 1, 12'h00F, "t3_blue");
        probe(301, 410, 1, 12'h0F0, "t3_green");

        // 4: mid-frame write stays pending; write during frame_start is held off a cycle
        cfg_write(2, 100, 100, 1, 0);
        probe(105, 105, 1, 12'h237, "t4_pending");
        @(negedge clk);
        frame_start = 1; cfg_valid = 1; cfg_layer = 3; cfg_x = 200; cfg_y = 100;
        cfg_show = 1; cfg_blink = 0;
        #1 check("t4_ready_fs", {31'h0, cfg_ready}, 32'h0);
        @(negedge clk); frame_start = 0;
        #1 check("t4_ready_next", {31'h0, cfg_ready}, 32'h1);
        @(negedge clk); cfg_valid = 0;
        probe(105, 105, 1, 12'hABC, "t4_l2_live");
        probe(205, 105, 1, 12'h237, "t4_l3_shadow");
        commit();
        probe(205, 105, 1, 12'h456, "t4_l3_live");

        // 5: blink with BLINK_FRAMES=2 from a clean reset
        @(negedge clk); reset = 1;
        @(negedge clk);
        @(negedge clk); reset = 0;
        cfg_write(4, 400, 200, 1, 1);
        for (int k = 0; k < 8; k++) begin
            commit();
            probe(405, 205, 1, blink_vis[k] ? 12'h777 : 12'h237, "t5_blink");
        end

        // 6: right/bottom edge clipping, no wrap; blanking overrides hits
        cfg_write(5, 1010, 500, 1, 0);
        commit();
        probe(1015, 505, 1, 12'hC0C, "t6_edge_hit");
        probe(5, 505, 1, 12'h237, "t6_no_xwrap");
        probe(1015, 5, 1, 12'h237, "t6_no_ywrap");
        probe(1015, 505, 0, 12'h000, "t6_blank");
        for (int px = 0; px < 10; px++) begin
            @(negedge clk); x = 10'(px); y = 505; active = 1;
        end
        for (int px = 1005; px < 1024; px++) begin
            @(negedge clk); x = 10'(px); y = 510; active = 1;
        end

        repeat (4) @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
